// File: rtl/subbytes_arbiter_if.sv
// Bus between the S-box arbiter, its two requesters (round state, key word) and the shared S-box.
interface subbytes_arbiter_if;
    logic         st_valid;
    logic         st_ready;
    logic [127:0] st_in;
    logic [127:0] st_out;
    logic         st_done;
    logic         kw_valid;
    logic         kw_ready;
    logic [31:0]  kw_in;
    logic [31:0]  kw_out;
    logic         kw_done;
    logic [7:0]   sb_in;
    logic         sb_en;
    logic [7:0]   sb_out;

    modport master (
        output st_valid, st_in, kw_valid, kw_in, sb_out,
        input  st_ready, st_out, st_done, kw_ready, kw_out, kw_done, sb_in, sb_en
    );

    modport slave (
        input  st_valid, st_in, kw_valid, kw_in, sb_out,
        output st_ready, st_out, st_done, kw_ready, kw_out, kw_done, sb_in, sb_en
    );
endinterface

// File: rtl/subbytes_arbiter.sv
// Shares one registered S-box between a 16-byte round-state SubBytes and a 4-byte SubWord,
// streaming one byte per cycle and arbitrating between the two requesters.
module subbytes_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input logic               clk,
    input logic               rst,
    subbytes_arbiter_if.slave bus
);
    typedef enum logic [1:0] {Idle, StRun, KwRun} state_e;

    state_e       state_q;
    logic [127:0] word_q;
    logic [127:0] acc_q;
    logic [127:0] acc_d;
    logic [127:0] st_out_q;
    logic [31:0]  kw_out_q;
    logic         st_done_q;
    logic         kw_done_q;
    logic         sb_en_q;
    logic [7:0]   sb_in_q;
    logic         pend_q;
    logic [3:0]   issue_idx_q;
    logic [3:0]   pend_idx_q;
    logic         last_st_q;
    logic [3:0]   last_idx;
    logic [7:0]   next_byte;
    logic         grant_st;
    logic         grant_kw;

    always_comb begin
        grant_st = 1'b0;
        grant_kw = 1'b0;
        if (!rst && state_q == Idle) begin
            grant_kw = bus.kw_valid && (!bus.st_valid || !RR_EN || last_st_q);
            grant_st = bus.st_valid && !grant_kw;
        end
    end

    // Key words sit in the top 32 bits of word_q/acc_q so byte k is always at 127-8k.
    assign last_idx  = (state_q == KwRun) ? 4'd3 : 4'd15;
    assign next_byte = word_q[7'd127 - {issue_idx_q + 4'd1, 3'b000} -: 8];

    always_comb begin
        acc_d = acc_q;
        acc_d[7'd127 - {pend_idx_q, 3'b000} -: 8] = bus.sb_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= Idle;
            st_out_q    <= '0;
            kw_out_q    <= '0;
            st_done_q   <= 1'b0;
            kw_done_q   <= 1'b0;
            sb_en_q     <= 1'b0;
            sb_in_q     <= 8'h00;
            pend_q      <= 1'b0;
            issue_idx_q <= '0;
            pend_idx_q  <= '0;
            last_st_q   <= 1'b1;
        end else begin
            st_done_q <= 1'b0;
            kw_done_q <= 1'b0;
            unique case (state_q)
                Idle: begin
                    if (grant_st || grant_kw) begin
                        state_q     <= grant_st ? StRun : KwRun;
                        word_q      <= grant_st ? bus.st_in : {bus.kw_in, 96'd0};
                        sb_in_q     <= grant_st ? bus.st_in[127:120] : bus.kw_in[31:24];
                        sb_en_q     <= 1'b1;
                        issue_idx_q <= '0;
                        pend_q      <= 1'b0;
                        last_st_q   <= grant_st;
                    end
                end
                default: begin
                    // The S-box result for the byte issued last cycle arrives now.
                    pend_q     <= sb_en_q;
                    pend_idx_q <= issue_idx_q;
                    if (pend_q) begin
                        acc_q <= acc_d;
                    end
                    if (sb_en_q) begin
                        if (issue_idx_q == last_idx) begin
                            sb_en_q <= 1'b0;
                            sb_in_q <= 8'h00;
                        end else begin
                            issue_idx_q <= issue_idx_q + 4'd1;
                            sb_in_q     <= next_byte;
                        end
                    end
                    if (pend_q && pend_idx_q == last_idx) begin
                        state_q <= Idle;
                        if (state_q == StRun) begin
                            st_out_q  <= acc_d;
                            st_done_q <= 1'b1;
                        end else begin
                            kw_out_q  <= acc_d[127:96];
                            kw_done_q <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.st_ready = grant_st;
    assign bus.kw_ready = grant_kw;
    assign bus.st_out   = st_out_q;
    assign bus.kw_out   = kw_out_q;
    assign bus.st_done  = st_done_q;
    assign bus.kw_done  = kw_done_q;
    assign bus.sb_in    = sb_in_q;
    assign bus.sb_en    = sb_en_q;
endmodule

// File: tb/tb_subbytes_arbiter.sv
// Bench for subbytes_arbiter: AES S-box model, per-byte SubBytes reference and arbitration checks.
module tb_subbytes_arbiter;
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [0:255][7:0] sbox_tab = SBOX;
    logic              clk = 1'b0;
    logic              rst;
    bit                x_inject = 1'b0;
    logic [7:0]        x_val = 8'h00;
    int                checks = 0;
    int                errors = 0;
    logic [127:0]      exp_st;
    logic [31:0]       exp_kw;

    subbytes_arbiter_if ifa ();
    subbytes_arbiter_if ifb ();

    subbytes_arbiter #(.RR_EN(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    subbytes_arbiter #(.RR_EN(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    always #5 clk = ~clk;

    // Registered S-box: result appears the cycle after the byte is presented.
    always @(posedge clk) begin
        if (ifa.sb_en) ifa.sb_out <= (x_inject && ifa.sb_in == x_val) ? 8'hxx : sbox_tab[ifa.sb_in];
        if (ifb.sb_en) ifb.sb_out <= sbox_tab[ifb.sb_in];
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] sub_bytes(input logic [127:0] w, input int n, input bit xin);
        logic [127:0] r = '0;
        for (int k = 0; k < n; k++) begin
            if (xin && w[127-8*k -: 8] == x_val) r[127-8*k -: 8] = 8'hxx;
            else r[127-8*k -: 8] = sbox_tab[w[127-8*k -: 8]];
        end
        return r;
    endfunction

    task automatic do_op(input bit is_kw, input logic [127:0] w, input bit rel_rst, input string tag);
        int           lat = -1;
        int           en_cnt = 0;
        bit           other_done = 1'b0;
        logic [127:0] t;
        @(negedge clk);
        if (is_kw) begin
            ifa.kw_valid = 1'b1;
            ifa.kw_in    = w[127:96];
        end else begin
            ifa.st_valid = 1'b1;
            ifa.st_in    = w;
        end
        if (rel_rst) rst = 1'b0;
        #1;
        check({tag, " ready"}, 128'(is_kw ? ifa.kw_ready : ifa.st_ready), 128'(1));
        for (int k = 1; k <= 30 && lat < 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                ifa.st_valid = 1'b0;
                ifa.kw_valid = 1'b0;
                ifa.st_in    = ~w;
                ifa.kw_in    = ~w[127:96];
            end
            #1;
            en_cnt += int'(ifa.sb_en);
            if (is_kw ? ifa.st_done : ifa.kw_done) other_done = 1'b1;
            if (is_kw ? ifa.kw_done : ifa.st_done) lat = k;
        end
        check({tag, " latency"}, 128'(lat), 128'(is_kw ? 6 : 18));
        check({tag, " sb_en cycles"}, 128'(en_cnt), 128'(is_kw ? 4 : 16));
        check({tag, " other done"}, 128'(other_done), 128'(0));
        t = sub_bytes(w, is_kw ? 4 : 16, x_inject);
        if (is_kw) exp_kw = t[127:96];
        else exp_st = t;
        check({tag, " st_out"}, ifa.st_out, exp_st);
        check({tag, " kw_out"}, 128'(ifa.kw_out), 128'(exp_kw));
    endtask

    initial begin
        logic [127:0] w;
        logic [7:0]   ga[$];
        logic [7:0]   da[$];
        int           both_rdy = 0;
        int           b_st = 0;
        int           b_kw = 0;
        int           b_done = 0;
        bit           seen_done = 1'b0;
        logic [127:0] wa_s;
        logic [127:0] wa_k;
        logic [127:0] wb_k;
        logic [127:0] t;

        rst = 1'b1;
        ifa.st_valid = 1'b1; ifa.kw_valid = 1'b1; ifa.st_in = '0; ifa.kw_in = '0;
        ifb.st_valid = 1'b1; ifb.kw_valid = 1'b1; ifb.st_in = '0; ifb.kw_in = '0;
        exp_st = '0;
        exp_kw = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst ready", 128'({ifa.st_ready, ifa.kw_ready, ifb.st_ready, ifb.kw_ready}), 128'(0));
        check("rst st_out", ifa.st_out, 128'(0));
        check("rst kw_out", 128'(ifa.kw_out), 128'(0));
        check("rst done/en", 128'({ifa.st_done, ifa.kw_done, ifa.sb_en}), 128'(0));
        check("rst sb_in", 128'(ifa.sb_in), 128'(0));
        ifa.st_valid = 1'b0; ifa.kw_valid = 1'b0;
        ifb.st_valid = 1'b0; ifb.kw_valid = 1'b0;

        do_op(1'b0, 128'h00112233445566778899aabbccddeeff, 1'b1, "st_vec");
        check("st_vec literal", ifa.st_out, 128'h638293c31bfc33f5c4eeacea4bc12816);
        do_op(1'b1, {32'hcf4f3c09, 96'd0}, 1'b0, "kw_vec");
        check("kw_vec literal", 128'(ifa.kw_out), 128'(32'h8a84eb01));
        check("kw_vec st kept", ifa.st_out, 128'h638293c31bfc33f5c4eeacea4bc12816);

        for (int i = 0; i < 5; i++) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 1) == 1) do_op(1'b1, {w[127:96], 96'd0}, 1'b0, "rand_kw");
            else do_op(1'b0, w, 1'b0, "rand_st");
        end

        x_inject = 1'b1;
        x_val    = 8'h5a;
        do_op(1'b0, 128'h0102030405065a0708090a0b0c0d0e0f, 1'b0, "x_byte");
        x_inject = 1'b0;
        do_op(1'b0, 128'hfedcba98765432100123456789abcdef, 1'b0, "x_flush");

        // Abort a round-state operation with reset 5 cycles in.
        @(negedge clk);
        ifa.st_valid = 1'b1;
        ifa.st_in    = 128'h3243f6a8885a308d313198a2e0370734;
        #1;
        check("abort ready", 128'(ifa.st_ready), 128'(1));
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) ifa.st_valid = 1'b0;
            if (k == 5) rst = 1'b1;
            #1;
            if (ifa.st_done) seen_done = 1'b1;
        end
        check("abort no done", 128'(seen_done), 128'(0));
        check("abort st_out", ifa.st_out, 128'(0));
        check("abort sb_en", 128'(ifa.sb_en), 128'(0));
        exp_st = '0;
        exp_kw = '0;
        do_op(1'b0, 128'h00000000000000000000000000000000, 1'b1, "post_rst");

        // Both requesters held valid from reset release.
        @(negedge clk);
        rst  = 1'b1;
        wa_s = {$urandom, $urandom, $urandom, $urandom};
        wa_k = {$urandom, 96'd0};
        wb_k = {$urandom, 96'd0};
        ifa.st_valid = 1'b1; ifa.kw_valid = 1'b1; ifa.st_in = wa_s; ifa.kw_in = wa_k[127:96];
        ifb.st_valid = 1'b1; ifb.kw_valid = 1'b1; ifb.st_in = wa_s; ifb.kw_in = wb_k[127:96];
        @(negedge clk);
        for (int c = 0; c < 52; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 0) rst = 1'b0;
            #1;
            if (ifa.st_ready && ifa.kw_ready) both_rdy++;
            if (ifa.kw_ready) ga.push_back("K");
            if (ifa.st_ready) ga.push_back("S");
            if (ifa.kw_done) da.push_back("K");
            if (ifa.st_done) da.push_back("S");
            if (ifb.st_ready) b_st++;
            if (ifb.kw_ready) b_kw++;
            if (ifb.kw_done) b_done++;
        end
        ifa.st_valid = 1'b0; ifa.kw_valid = 1'b0;
        ifb.st_valid = 1'b0; ifb.kw_valid = 1'b0;
        check("rr both ready", 128'(both_rdy), 128'(0));
        check("rr grant order", 128'({ga[0], ga[1], ga[2], ga[3]}), 128'("KSKS"));
        check("rr grant count", 128'(ga.size()), 128'(5));
        check("rr done order", 128'({da[0], da[1], da[2], da[3]}), 128'("KSKS"));
        check("rr st_out", ifa.st_out, sub_bytes(wa_s, 16, 1'b0));
        t = sub_bytes(wa_k, 4, 1'b0);
        check("rr kw_out", 128'(ifa.kw_out), 128'(t[127:96]));
        check("fixed st grants", 128'(b_st), 128'(0));
        check("fixed kw grants", 128'(b_kw), 128'(9));
        check("fixed kw dones", 128'(b_done), 128'(8));
        t = sub_bytes(wb_k, 4, 1'b0);
        check("fixed kw_out", 128'(ifb.kw_out), 128'(t[127:96]));
        check("fixed st_out", ifb.st_out, 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
